bus_rr_arbiter: RTL and testbench

//   Round-robin bus arbiter for N masters sharing the system bus. Replaces the fixed-priority grant scheme.

---
 rtl/bus_arb_pkg.sv | 20 ++
 rtl/rr_priority_pick.sv | 44 ++++
 rtl/bus_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, limits and helpers for the round-robin bus arbiter
// Purpose : FSM state encoding, master-count limit and the id-width helper used by
//           bus_rr_arbiter and rr_priority_pick.
// Ports   : none (package)
package bus_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Width of a master index; never less than one bit so a 2-master bus still has an id.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating priority encoder
// Purpose : picks the first set request bit, searching upward from the master after
//           last_ptr and wrapping at NUM_MASTERS-1 -> 0.
// Ports   : req      in  NUM_MASTERS  request vector
//           last_ptr in  IDW          index of the most recently released master
//           pick     out NUM_MASTERS  one-hot winner (zero when nobody requests)
//           pick_id  out IDW          index of the winner (zero when nobody requests)
//           any      out 1            at least one request is set
module rr_priority_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  localparam int IDW = clog2_min1(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDW-1:0]         last_ptr,
  output logic [NUM_MASTERS-1:0] pick,
  output logic [IDW-1:0]         pick_id,
  output logic                   any
);

  always_comb begin
    int idx;
    logic [NUM_MASTERS-1:0] shifted;
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = 0;
    shifted = '0;
    // Offsets 1..N visit every master once, the last_ptr master itself last,
    // which gives the just-released master the lowest priority.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(last_ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      shifted = req >> idx;
      if (!any && shifted[0]) begin
        any     = 1'b1;
        pick    = NUM_MASTERS'(1) << idx;
        pick_id = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin bus arbiter with transaction-locked grants
// Purpose : grants the shared bus to one master at a time, holds the grant until the
//           owner strobes done or drops req, inserts one dead cycle between grants,
//           and rotates priority so the last owner goes to the back of the line.
//           Optional watchdog (macro BUS_ARB_TIMEOUT_EN) forces release after
//           TIMEOUT_CYCLES grant cycles and pulses timeout_err.
// Ports   : clk         in  1            clock, rising edge
//           reset       in  1            asynchronous active-high reset
//           req         in  NUM_MASTERS  level request per master
//           done        in  NUM_MASTERS  one-cycle end-of-transaction strobe per master
//           gnt         out NUM_MASTERS  registered one-hot grant
//           gnt_id      out IDW          index of granted master, 0 when idle
//           bus_busy    out 1            any grant bit set
//           timeout_err out 1            one-cycle watchdog release pulse
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDW = clog2_min1(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] done,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDW-1:0]         gnt_id,
  output logic                   bus_busy,
  output logic                   timeout_err
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
    $error("bus_rr_arbiter: NUM_MASTERS out of range");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("bus_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t             state, state_n;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic [IDW-1:0]         gnt_id_n;
  logic                   bus_busy_n;
  logic                   timeout_err_n;
  logic [IDW-1:0]         last_ptr, last_ptr_n;

  logic [NUM_MASTERS-1:0] pick;
  logic [IDW-1:0]         pick_id;
  logic                   pick_any;

  // Only the current owner's strobes matter; everyone else is ignored while locked.
  logic owner_done;
  logic owner_req;
  assign owner_done = |(done & gnt);
  assign owner_req  = |(req & gnt);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HCW = $clog2(TIMEOUT_CYCLES);
  logic [HCW-1:0] hold_cnt, hold_cnt_n;
`endif

  rr_priority_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .pick     (pick),
    .pick_id  (pick_id),
    .any      (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      last_ptr    <= IDW'(NUM_MASTERS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      gnt_id      <= gnt_id_n;
      bus_busy    <= bus_busy_n;
      timeout_err <= timeout_err_n;
      last_ptr    <= last_ptr_n;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt    <= hold_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n       = state;
    gnt_n         = gnt;
    gnt_id_n      = gnt_id;
    bus_busy_n    = bus_busy;
    timeout_err_n = 1'b0;
    last_ptr_n    = last_ptr;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_cnt_n    = hold_cnt;
`endif

    case (state)
      // The dead cycle arbitrates exactly like idle; last_ptr already points at
      // the master that just released.
      ST_IDLE, ST_RELEASE: begin
        if (pick_any) begin
          state_n    = ST_GRANT;
          gnt_n      = pick;
          gnt_id_n   = pick_id;
          bus_busy_n = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end else begin
          state_n    = ST_IDLE;
          gnt_n      = '0;
          gnt_id_n   = '0;
          bus_busy_n = 1'b0;
        end
      end

      ST_GRANT: begin
        // done and abandon in the same cycle are one release; a done that lands on
        // the watchdog expiry edge wins and suppresses the error.
        if (owner_done || !owner_req) begin
          state_n    = ST_RELEASE;
          gnt_n      = '0;
          gnt_id_n   = '0;
          bus_busy_n = 1'b0;
          last_ptr_n = gnt_id;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_cnt == HCW'(TIMEOUT_CYCLES - 1)) begin
          state_n       = ST_RELEASE;
          gnt_n         = '0;
          gnt_id_n      = '0;
          bus_busy_n    = 1'b0;
          last_ptr_n    = gnt_id;
          timeout_err_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
`endif
      end

      default: begin
        state_n    = ST_IDLE;
        gnt_n      = '0;
        gnt_id_n   = '0;
        bus_busy_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter
// Purpose : table vectors, hand-written corner sequences and randomized traffic
//           compared against an ownership-level reference model.
// Ports   : none (top-level bench)
module tb_bus_rr_arbiter;

  localparam int N   = 3;
  localparam int T   = 4;
  localparam int IDW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic         bus_busy;
  logic         timeout_err;

  always #5 clk = ~clk;

  bus_rr_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus (-1 = nobody), who released last, how long
  // the owner has held it, and whether the last edge was a watchdog release.
  int m_owner;
  int m_last;
  int m_hold;
  int m_err;

  typedef struct {
    logic         rst;
    logic [N-1:0] r;
    logic [N-1:0] d;
    logic [N-1:0] exp_gnt;
    logic [IDW-1:0] exp_id;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return int'(s[0]);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_hold  = 0;
    m_err   = 0;
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (bit_of(r, i) == 1) return i;
    end
    return -1;
  endfunction

  // Free bus (idle or the dead cycle) grants the rotating winner; an owned bus is
  // freed by done/abandon or, in the watchdog build, after T cycles of ownership.
  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
    m_err = 0;
    if (m_owner < 0) begin
      m_owner = model_pick(r);
      m_hold  = 0;
    end else if (bit_of(d, m_owner) == 1 || bit_of(r, m_owner) == 0) begin
      m_last  = m_owner;
      m_owner = -1;
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      if (m_hold == T - 1) begin
        m_last  = m_owner;
        m_owner = -1;
        m_err   = 1;
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic cmp_model();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("model_gnt", 32'(gnt), 32'(eg));
    check("model_gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("model_bus_busy", 32'(bus_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("model_timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  // Called at a negedge; drives inputs, lets one rising edge pass, compares 1ns
  // later and returns at the following negedge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_busy", 32'(bus_busy), 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold_gnt", 32'(gnt), 32'd0);
    check("reset_hold_id", 32'(gnt_id), 32'd0);
    check("reset_hold_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d,
                     input logic [N-1:0] g, input logic [IDW-1:0] id);
    vec_t v;
    v.rst = rst; v.r = r; v.d = d; v.exp_gnt = g; v.exp_id = id;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] rr;
    logic [N-1:0] dd;

    reset = 1'b1;
    req   = '0;
    done  = '0;
    model_reset();

    // All requesting through reset, then full rotation with done two cycles in;
    // then master 1 abandoning while master 0 waits, with a stray done[0].
    add(1, 3'b111, 3'b000, 3'b001, 2'd0);
    add(0, 3'b111, 3'b000, 3'b001, 2'd0);
    add(0, 3'b111, 3'b001, 3'b000, 2'd0);
    add(0, 3'b111, 3'b000, 3'b010, 2'd1);
    add(0, 3'b111, 3'b000, 3'b010, 2'd1);
    add(0, 3'b111, 3'b010, 3'b000, 2'd0);
    add(0, 3'b111, 3'b000, 3'b100, 2'd2);
    add(0, 3'b111, 3'b000, 3'b100, 2'd2);
    add(0, 3'b111, 3'b100, 3'b000, 2'd0);
    add(0, 3'b111, 3'b000, 3'b001, 2'd0);
    add(1, 3'b010, 3'b000, 3'b010, 2'd1);
    add(0, 3'b011, 3'b001, 3'b010, 2'd1);
    add(0, 3'b001, 3'b000, 3'b000, 2'd0);
    add(0, 3'b001, 3'b000, 3'b001, 2'd0);
    add(0, 3'b000, 3'b001, 3'b000, 2'd0);
    add(0, 3'b000, 3'b000, 3'b000, 2'd0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        req = tbl[i].r;
        apply_reset();
      end
      step(tbl[i].r, tbl[i].d);
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
      check($sformatf("tbl%0d_id", i), 32'(gnt_id), 32'(tbl[i].exp_id));
    end

    // Lone master 2 re-granted after each dead cycle, then wrap to master 0.
    req = '0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(3'b100, 3'b000);
      check("solo2_gnt", 32'(gnt), 32'b100);
      check("solo2_id", 32'(gnt_id), 32'd2);
      step(3'b100, 3'b100);
      check("solo2_dead", 32'(gnt), 32'd0);
    end
    step(3'b101, 3'b000);
    check("wrap_gnt", 32'(gnt), 32'b001);

    // Asynchronous reset in the middle of a grant.
    apply_reset();
    step(3'b011, 3'b000);
    step(3'b011, 3'b000);
    check("pre_rst_gnt", 32'(gnt), 32'b001);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_busy", 32'(bus_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(3'b011, 3'b000);
    check("post_rst_gnt", 32'(gnt), 32'b001);

    // Watchdog behaviour, or indefinite hold without it.
    apply_reset();
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < T; i++) begin
      step(3'b011, 3'b000);
      check("wd_hold_gnt", 32'(gnt), 32'b001);
      check("wd_hold_err", 32'(timeout_err), 32'd0);
    end
    step(3'b011, 3'b000);
    check("wd_expire_gnt", 32'(gnt), 32'd0);
    check("wd_expire_err", 32'(timeout_err), 32'd1);
    step(3'b011, 3'b000);
    check("wd_next_gnt", 32'(gnt), 32'b010);
    check("wd_next_err", 32'(timeout_err), 32'd0);
    apply_reset();
    for (int i = 0; i < T; i++) step(3'b001, 3'b000);
    step(3'b001, 3'b001);
    check("wd_done_wins_gnt", 32'(gnt), 32'd0);
    check("wd_done_wins_err", 32'(timeout_err), 32'd0);
    step(3'b000, 3'b000);
`else
    for (int i = 0; i < 100; i++) begin
      step(3'b011, 3'b000);
      check("nowd_hold_gnt", 32'(gnt), 32'b001);
      check("nowd_err", 32'(timeout_err), 32'd0);
    end
    step(3'b000, 3'b000);
`endif

    // Randomized traffic against the model.
    apply_reset();
    rr = '0;
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < N; m++) begin
        if (rr[m] == 1'b0) begin
          if ($urandom_range(0, 2) == 0) rr[m] = 1'b1;
        end else if ($urandom_range(0, 11) == 0) begin
          rr[m] = 1'b0;
        end
        dd[m] = ($urandom_range(0, 5) == 0);
      end
      step(rr, dd);
      for (int m = 0; m < N; m++) begin
        if (dd[m] && ($urandom_range(0, 1) == 0)) rr[m] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
